// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg -- state encoding and baud constants shared by the UART TX and RX
// Rev 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int CLKS_9600_50MHZ   = 5208;
    localparam int CLKS_115200_50MHZ = 434;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo -- synchronous power-of-two FIFO buffering bytes for uart_tx
// Rev 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a pop in the same cycle
    // never opens room for a push.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx -- buffered 8N1/8N2 UART transmitter with registered serial output
// Rev 1.0
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_9600_50MHZ,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    txData,
    input  logic                          txValid,
    output logic                          txReady,
    output logic                          TX,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t state, state_nx;
    logic [15:0] baud, baud_nx;
    logic [2:0]  bit_cnt, bit_nx;
    logic [7:0]  shift, shift_nx;
    logic [7:0]  head;
    logic        tx_nx;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        baud_tick;

    assign txReady   = !full;
    assign push      = txValid && txReady;
    assign baud_tick = (baud == BAUD_LAST);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (txData),
        .dout  (head),
        .count (fifoCount),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        baud_nx  = baud;
        bit_nx   = bit_cnt;
        shift_nx = shift;
        pop      = 1'b0;
        tx_nx    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shift_nx = head;
                    baud_nx  = '0;
                    bit_nx   = '0;
                    state_nx = START;
                end
            end
            START: begin
                tx_nx = 1'b0;
                if (baud_tick) begin
                    baud_nx  = '0;
                    state_nx = DATA;
                end else begin
                    baud_nx = baud + 16'd1;
                end
            end
            DATA: begin
                tx_nx = shift[0];
                if (baud_tick) begin
                    baud_nx  = '0;
                    shift_nx = {1'b0, shift[7:1]};
                    bit_nx   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nx = STOP;
                end else begin
                    baud_nx = baud + 16'd1;
                end
            end
            STOP: begin
                // bit_cnt wrapped to 0 leaving DATA and now counts stop bits
                if (baud_tick) begin
                    baud_nx = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_nx = '0;
                        if (!empty) begin
                            pop      = 1'b1;
                            shift_nx = head;
                            state_nx = START;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        bit_nx = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_nx = baud + 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // TX and busy are registered from the current state, so both trail the
    // state register by one clock and stay aligned with each other.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            TX      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_cnt <= bit_nx;
            shift   <= shift_nx;
            TX      <= tx_nx;
            busy    <= (state != IDLE) || !empty;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per serial bit (9600 baud at 50 MHz); legal range 4..65535.
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit buffer entries; power of two, 2..16.
REQ-004 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port: txData  input  8  byte to enqueue.
REQ-007 Port: txValid  input  1  txData valid this cycle.
REQ-008 Port: txReady  output  1  buffer can accept a byte this cycle.
REQ-009 Port: TX  output  1  serial line, idle high, registered.
REQ-010 Port: busy  output  1  high while a frame is on the line or the buffer is non-empty.
REQ-011 Port: fifoCount  output  clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-012 Frame SHALL be 8N1 (or 8N2): start bit 0, data bits LSB first, STOP_BITS stop bits of 1, each exactly CLKS_PER_BIT cycles.
REQ-013 A byte SHALL be accepted on any rising edge where txValid and txReady are both high; otherwise txData SHALL be ignored.
REQ-014 txReady SHALL equal (fifoCount < FIFO_DEPTH), derived from registered count; a simultaneous pop SHALL NOT make a full buffer accept a byte in the same cycle.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE: TX=1; when fifoCount>0, pop head into shift register, clear baud and bit counters, go to START.
REQ-017 START: TX=0 for CLKS_PER_BIT cycles, then DATA.
REQ-018 DATA: TX=shift[0]; after CLKS_PER_BIT cycles shift right and increment the 3-bit bit counter; after bit 7 go to STOP.
REQ-019 STOP: TX=1 for STOP_BITS*CLKS_PER_BIT cycles; at end, if fifoCount>0 pop and go directly to START (no idle gap), else go to IDLE.
REQ-020 Latency: byte accepted at edge N into an empty buffer with FSM in IDLE SHALL drive TX low from edge N+2.
REQ-021 Back-to-back frames SHALL be exactly (9+STOP_BITS)*CLKS_PER_BIT cycles apart at the start-bit falling edge.
REQ-022 Simultaneous push and pop SHALL leave fifoCount unchanged and preserve byte order.
REQ-023 Push into empty buffer while FSM is in IDLE SHALL NOT bypass the buffer; pop occurs the following cycle.
REQ-024 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; fifoCount SHALL never exceed FIFO_DEPTH or go below 0.
REQ-025 Baud counter SHALL be 16 bits, counting 0..CLKS_PER_BIT-1; no fractional baud adjustment.
REQ-026 busy SHALL be (state != IDLE) || (fifoCount != 0), registered.

Reset
REQ-027 While rst_n=0 at a rising edge: state=IDLE, TX=1, busy=0, fifoCount=0, txReady=1 after release, pointers and counters=0.
REQ-028 Reset mid-frame SHALL abort the frame; TX SHALL be 1 on the first edge with rst_n=0; buffered bytes SHALL be discarded.
REQ-029 No byte SHALL be accepted on an edge where rst_n=0.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state encoding and baud constants (CLKS_9600_50MHZ=5208, CLKS_115200_50MHZ=434) for use by both uart_tx and the existing receiver.
REQ-031 Buffer SHALL be a sub-module uart_tx_fifo (sync FIFO: push, pop, dout, count, full, empty); FSM, shift register and counters SHALL live in uart_tx.

Verification (CLKS_PER_BIT=4, STOP_BITS=1, FIFO_DEPTH=4 unless stated)
REQ-032 Single byte 0xA5 pushed at edge 10 -> TX low at edge 12 for 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then high 4 cycles; busy falls after stop; an independent bit-sampling monitor decodes 0xA5.
REQ-033 Push 0x00,0xFF,0x55,0xAA on consecutive edges -> all accepted, start bits 40 cycles apart, decoded in order, no idle between frames.
REQ-034 Hold txValid high with six bytes while a frame is active -> txReady low once fifoCount=4, exactly the bytes with txReady=1 transmitted, none lost or duplicated.
REQ-035 Assert rst_n=0 during DATA bit 3 of 0x3C with 2 bytes buffered -> TX=1 next edge, fifoCount=0, busy=0; nothing transmitted after release until a new push.
REQ-036 STOP_BITS=2, push 0x81 twice -> stop interval 8 cycles, start bits 44 cycles apart.
REQ-037 Push while full coinciding with a pop -> byte rejected (txReady was 0), fifoCount ends at 3.
